// File: rtl/wr_arbiter.sv
// wr_arbiter: merges CPU writes with FIFO-buffered debug writes onto one registered memory write port
module wr_arbiter #(
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  dbg_we_i,
  input  logic [15:0]           dbg_waddr_i,
  input  logic [15:0]           dbg_wdata_i,
  input  logic                  cpu_we_i,
  input  logic [15:0]           cpu_waddr_i,
  input  logic [15:0]           cpu_wdata_i,
  input  logic                  dbg_ovf_clr_i,
  output logic                  mem_we_o,
  output logic [15:0]           mem_waddr_o,
  output logic [15:0]           mem_wdata_o,
  output logic [DEPTH_LOG2:0]   dbg_count_o,
  output logic                  dbg_full_o,
  output logic                  dbg_ovf_o
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  logic [31:0]           fifo [DEPTH];
  logic [DEPTH_LOG2-1:0] rd_ptr, wr_ptr;
  logic [DEPTH_LOG2:0]   count;
  logic                  full, pop, push, drop;
  assign full        = count == (DEPTH_LOG2+1)'(DEPTH);
  assign pop         = !cpu_we_i && count != '0;
  assign push        = dbg_we_i && (!full || pop);
  assign drop        = dbg_we_i && full && !pop;
  assign dbg_count_o = count;
  assign dbg_full_o  = full;
  // FIFO storage needs no reset; stale entries are unreachable once the pointers clear
  always_ff @(posedge clk)
    if (push && !reset) fifo[wr_ptr] <= {dbg_waddr_i, dbg_wdata_i};
  // occupancy and wrap-around pointers; a full FIFO may still accept a push when it pops the same cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      count  <= (push && !pop) ? count + (DEPTH_LOG2+1)'(1) :
                (pop && !push) ? count - (DEPTH_LOG2+1)'(1) : count;
      rd_ptr <= pop  ? rd_ptr + DEPTH_LOG2'(1) : rd_ptr;
      wr_ptr <= push ? wr_ptr + DEPTH_LOG2'(1) : wr_ptr;
    end
  end
  // merged write port: CPU always wins, otherwise the FIFO head drains; address/data hold when idle
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_we_o    <= 1'b0;
      mem_waddr_o <= '0;
      mem_wdata_o <= '0;
    end else begin
      mem_we_o    <= cpu_we_i || pop;
      mem_waddr_o <= cpu_we_i ? cpu_waddr_i : pop ? fifo[rd_ptr][31:16] : mem_waddr_o;
      mem_wdata_o <= cpu_we_i ? cpu_wdata_i : pop ? fifo[rd_ptr][15:0]  : mem_wdata_o;
    end
  end
  // sticky overflow flag; a drop in the same cycle as a clear keeps it set
  always_ff @(posedge clk)
    if (reset) dbg_ovf_o <= 1'b0;
    else dbg_ovf_o <= drop ? 1'b1 : dbg_ovf_clr_i ? 1'b0 : dbg_ovf_o;
endmodule
